async_fifo_multi_sync: RTL and testbench
========================================

ASYNC_FIFO_MULTI_SYNC -- requirements
Module: async_fifo_multi_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: number of independent synchronized channels.
REQ-002 The block SHALL have parameter FLOP_CNT, default 2: synchronizer depth per channel, legal range 2..4.
REQ-003 The block SHALL have parameter FILTER_CNT, default 0: consecutive stable cycles required before the output changes; 0 means filter bypass.
REQ-004 The block SHALL have parameter RESET_VAL, default all-zero, WIDTH bits: per-channel reset level of all flops and of q.
REQ-005 The block SHALL have port clk  input  1  destination clock; the single clock of the block.
REQ-006 The block SHALL have port reset  input  1  reset, synchronous to clk and active-high.
REQ-007 The block SHALL have port d  input  WIDTH  asynchronous channel inputs.
REQ-008 The block SHALL have port q  output  WIDTH  synchronized and filtered levels.
REQ-009 The block SHALL have port rise  output  WIDTH  one-cycle pulse marking a 0->1 change of q.
REQ-010 The block SHALL have port fall  output  WIDTH  one-cycle pulse marking a 1->0 change of q.

Function
REQ-011 Each channel SHALL register d[i] through a chain of exactly FLOP_CNT flops; only the first flop samples d[i]; s[i] denotes the last flop.
REQ-012 Channels SHALL be fully independent; no logic is shared across bits.
REQ-013 With FILTER_CNT=0, q[i] SHALL equal s[i]; latency is FLOP_CNT edges from the first sampling edge.
REQ-014 With FILTER_CNT>0, each channel SHALL hold a counter of width clog2(FILTER_CNT+1): cleared when s[i]==q[i], incremented when s[i]!=q[i].
REQ-015 When s[i]!=q[i] and counter==FILTER_CNT-1, q[i] SHALL load s[i] and the counter SHALL clear at that edge; latency is FLOP_CNT+FILTER_CNT edges.
REQ-016 A run at s[i] opposite to q[i] shorter than FILTER_CNT cycles SHALL leave q[i] unchanged and SHALL clear the counter on return.
REQ-017 rise[i] SHALL be registered and high for exactly the first cycle in which q[i] shows 1 after showing 0; fall[i] likewise for 1->0.
REQ-018 rise[i] and fall[i] SHALL never both be high; different channels may pulse in the same cycle.
REQ-019 The counter SHALL never exceed FILTER_CNT-1; there is no wrap-around.

Reset
REQ-020 While reset is high at a clk edge, all sync flops and q SHALL load RESET_VAL, counters SHALL load 0, and rise and fall SHALL load 0.
REQ-021 No rise or fall pulse SHALL occur on the reset edge or on the first edge after reset deasserts, unless q genuinely changes at that edge.
REQ-022 Reset asserted mid-count SHALL abandon the pending change; counting restarts from 0 after deassertion.

Structure
REQ-023 Package async_fifo_sync_pkg SHALL hold FLOP_CNT_MIN=2, FLOP_CNT_MAX=4 and the counter-width function.
REQ-024 Per-channel logic SHALL live in sub-module async_fifo_sync_chan (one bit: chain, filter, edge pulses), instantiated WIDTH times by generate.
REQ-025 Under ASSERT_ON, elaboration SHALL $fatal when FLOP_CNT is outside 2..4 or when WIDTH<1.

Verification (WIDTH=4, FLOP_CNT=2, FILTER_CNT=3 unless stated)
REQ-026 Reset with RESET_VAL=4'b0101 -> q=4'b0101, rise=fall=0 on the first cycle after reset and on all following cycles while d=4'b0101.
REQ-027 d[0] 0->1 and held -> q[0]=1 exactly 5 edges after the first sampling edge, rise[0] high for 1 cycle, fall=0.
REQ-028 d[1] high for 2 cycles, then low -> q[1] stays 0, rise[1] and fall[1] stay 0.
REQ-029 d[0] 0->1 and d[2] 1->0 at the same edge -> rise[0] and fall[2] pulse in the same cycle.
REQ-030 d[3] 0->1, reset pulsed 1 cycle at count 2 -> q[3]=0 with no pulse; q[3]=1 at 5 edges after deassertion.
REQ-031 FLOP_CNT=3, FILTER_CNT=0, d[0] 0->1 -> q[0]=1 after 3 edges, rise[0] pulses once.

Source files
------------

// File: rtl/async_fifo_sync_pkg.sv
// Shared constants and helpers for the multi-channel level synchronizer.
// Holds the legal synchronizer depth range and the filter counter width.
package async_fifo_sync_pkg;

    localparam int unsigned FLOP_CNT_MIN = 2;
    localparam int unsigned FLOP_CNT_MAX = 4;

    // A bypassed filter still gets a 1-bit width so declarations stay legal.
    function automatic int unsigned cnt_width(input int unsigned filter_cnt);
        return (filter_cnt == 0) ? 1 : $clog2(filter_cnt + 1);
    endfunction

endpackage

// File: rtl/async_fifo_sync_chan.sv
// One synchronized channel: flop chain, optional stability filter and
// registered rise/fall pulses on the filtered level.
module async_fifo_sync_chan
    import async_fifo_sync_pkg::*;
#(
    parameter int unsigned FLOP_CNT   = 2,
    parameter int unsigned FILTER_CNT = 0,
    parameter logic        RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [FLOP_CNT-1:0] chain_q;
    logic                s;
    logic                q_nxt;
    logic                rise_q;
    logic                fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= {FLOP_CNT{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[FLOP_CNT-2:0], d};
        end
    end

    assign s = chain_q[FLOP_CNT-1];

    generate
        if (FILTER_CNT == 0) begin : g_bypass
            assign q     = s;
            // Next value of q is whatever shifts into the last flop.
            assign q_nxt = chain_q[FLOP_CNT-2];
        end else begin : g_filter
            localparam int unsigned CW = cnt_width(FILTER_CNT);
            localparam logic [CW-1:0] CntLast = CW'(FILTER_CNT - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          q_q;

            always_comb begin
                cnt_d = '0;
                q_nxt = q_q;
                if (s != q_q) begin
                    if (cnt_q == CntLast) begin
                        q_nxt = s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                    q_q   <= RESET_VAL;
                end else begin
                    cnt_q <= cnt_d;
                    q_q   <= q_nxt;
                end
            end

            assign q = q_q;
        end
    endgenerate

    // Pulses are registered alongside q so they appear in the cycle q changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= q_nxt & ~q;
            fall_q <= ~q_nxt & q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/async_fifo_multi_sync.sv
// WIDTH independent level synchronizers with optional glitch filter and
// edge pulses, all in the destination clock domain.
module async_fifo_multi_sync
    import async_fifo_sync_pkg::*;
#(
    parameter int unsigned      WIDTH      = 1,
    parameter int unsigned      FLOP_CNT   = 2,
    parameter int unsigned      FILTER_CNT = 0,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

`ifdef ASSERT_ON
    generate
        if (FLOP_CNT < FLOP_CNT_MIN || FLOP_CNT > FLOP_CNT_MAX) begin : g_bad_flop_cnt
            $fatal(1, "async_fifo_multi_sync: FLOP_CNT=%0d outside %0d..%0d",
                   FLOP_CNT, FLOP_CNT_MIN, FLOP_CNT_MAX);
        end
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "async_fifo_multi_sync: WIDTH must be at least 1");
        end
    endgenerate
`endif

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            async_fifo_sync_chan #(
                .FLOP_CNT   (FLOP_CNT),
                .FILTER_CNT (FILTER_CNT),
                .RESET_VAL  (RESET_VAL[i])
            ) u_chan (
                .clk   (clk),
                .reset (reset),
                .d     (d[i]),
                .q     (q[i]),
                .rise  (rise[i]),
                .fall  (fall[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_async_fifo_multi_sync.sv
// Directed bench: filtered 4-channel instance plus an unfiltered 3-deep
// instance, with hand-computed expectations per edge.
module tb_async_fifo_multi_sync;

    logic       clk;
    logic       reset;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] d2;
    logic [3:0] q2;
    logic [3:0] rise2;
    logic [3:0] fall2;

    int total;
    int bad;

    async_fifo_multi_sync #(
        .WIDTH      (4),
        .FLOP_CNT   (2),
        .FILTER_CNT (3),
        .RESET_VAL  (4'b0101)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q),
        .rise  (rise),
        .fall  (fall)
    );

    async_fifo_multi_sync #(
        .WIDTH      (4),
        .FLOP_CNT   (3),
        .FILTER_CNT (0),
        .RESET_VAL  (4'b0000)
    ) dut_fast (
        .clk   (clk),
        .reset (reset),
        .d     (d2),
        .q     (q2),
        .rise  (rise2),
        .fall  (fall2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int k, input logic [3:0] got,
                       input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s k=%0d got=%b want=%b", name, k, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d     = 4'b0101;
        d2    = 4'b0000;
        tick();
        tick();
        total++;
        if (q !== 4'b0101) begin
            bad++;
            $display("FAIL reset_q got=%b want=%b", q, 4'b0101);
        end
        total++;
        if ((rise | fall) !== 4'b0000) begin
            bad++;
            $display("FAIL reset_pulse got=%b want=%b", rise | fall, 4'b0000);
        end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("post_reset_q", k, q, 4'b0101);
            chk("post_reset_rise", k, rise, 4'b0000);
            chk("post_reset_fall", k, fall, 4'b0000);
            chk("post_reset_q2", k, q2, 4'b0000);
        end
    endtask

    // Single channel step: q flips on the 5th edge, pulse only there.
    task automatic test_edge(input int ch, input logic val);
        logic [3:0] onehot;
        logic       want_q;
        onehot = 4'b0001 << ch;
        d[ch]  = val;
        for (int k = 1; k <= 6; k++) begin
            tick();
            want_q = (k >= 5) ? val : ~val;
            total++;
            if (q[ch] !== want_q) begin
                bad++;
                $display("FAIL edge_q ch=%0d k=%0d got=%b want=%b", ch, k, q[ch], want_q);
            end
            chk("edge_rise", k, rise, (k == 5 && val) ? onehot : 4'b0000);
            chk("edge_fall", k, fall, (k == 5 && !val) ? onehot : 4'b0000);
        end
    endtask

    task automatic test_glitch();
        d[1] = 1'b1;
        tick();
        tick();
        d[1] = 1'b0;
        for (int k = 3; k <= 9; k++) begin
            tick();
            chk("glitch_q", k, q, 4'b0101);
            chk("glitch_pulse", k, rise | fall, 4'b0000);
        end
    endtask

    // A run of exactly FILTER_CNT cycles is the shortest one that passes.
    task automatic test_min_pulse();
        d[1] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) d[1] = 1'b0;
            tick();
            chk("minp_q", k, q, (k >= 5 && k < 8) ? 4'b0111 : 4'b0101);
            chk("minp_rise", k, rise, (k == 5) ? 4'b0010 : 4'b0000);
            chk("minp_fall", k, fall, (k == 8) ? 4'b0010 : 4'b0000);
        end
    endtask

    task automatic test_back_to_back();
        d[0] = 1'b1;
        d[2] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("b2b_q", k, q, (k >= 5) ? 4'b0001 : 4'b0100);
            chk("b2b_rise", k, rise, (k == 5) ? 4'b0001 : 4'b0000);
            chk("b2b_fall", k, fall, (k == 5) ? 4'b0100 : 4'b0000);
        end
    endtask

    task automatic test_reset_mid();
        d[3] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("mid_pre_q", k, q, 4'b0001);
            chk("mid_pre_pulse", k, rise | fall, 4'b0000);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_q", 0, q, 4'b0101);
        chk("mid_rst_pulse", 0, rise | fall, 4'b0000);
        // d=1001 against reset level 0101: ch3 rises, ch2 falls.
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("mid_q", k, q, (k >= 5) ? 4'b1001 : 4'b0101);
            chk("mid_rise", k, rise, (k == 5) ? 4'b1000 : 4'b0000);
            chk("mid_fall", k, fall, (k == 5) ? 4'b0100 : 4'b0000);
        end
    endtask

    task automatic test_bypass();
        d2[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("byp_q", k, q2, (k >= 3) ? 4'b0001 : 4'b0000);
            chk("byp_rise", k, rise2, (k == 3) ? 4'b0001 : 4'b0000);
            chk("byp_fall", k, fall2, 4'b0000);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_edge(0, 1'b0);
        test_edge(0, 1'b1);
        test_glitch();
        test_min_pulse();
        test_edge(0, 1'b0);
        test_back_to_back();
        test_reset_mid();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
